// File: rtl/ber_snap_pkg.sv
// ============================================================================
// Module      : ber_snap_pkg
// Description : Shared address map, FSM encoding and status-word layout for the
//               BER snapshot register block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ber_snap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] ADDR_SNAP     = 4'h0;
    localparam logic [3:0] ADDR_ERR_I_LO = 4'h1;
    localparam logic [3:0] ADDR_ERR_I_HI = 4'h2;
    localparam logic [3:0] ADDR_TOT_I_LO = 4'h3;
    localparam logic [3:0] ADDR_TOT_I_HI = 4'h4;
    localparam logic [3:0] ADDR_ERR_Q_LO = 4'h5;
    localparam logic [3:0] ADDR_ERR_Q_HI = 4'h6;
    localparam logic [3:0] ADDR_TOT_Q_LO = 4'h7;
    localparam logic [3:0] ADDR_TOT_Q_HI = 4'h8;
    localparam logic [3:0] ADDR_STATUS   = 4'h9;
    localparam logic [3:0] ADDR_TSTAMP   = 4'hA;

    localparam logic [31:0] ILLEGAL_RDATA = 32'hDEADBEEF;

    localparam int STAT_SYNC_I     = 0;
    localparam int STAT_SYNC_Q     = 1;
    localparam int STAT_SNAP_VALID = 2;
    localparam int STAT_REQ_DROP   = 3;
    localparam int STAT_CNT_LSB    = 16;
    localparam int STAT_CNT_MSB    = 31;

endpackage

`default_nettype wire

// File: rtl/ber_snap_word_mux.sv
// ============================================================================
// Module      : ber_snap_word_mux
// Description : Combinational address-to-word selection for snapshot reads.
//               Optional macro BER_SNAP_TIMESTAMP_EN adds the 0xA timestamp word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ber_snap_word_mux
    import ber_snap_pkg::*;
(
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_snap_count,
    input  logic [63:0] i_err_I,
    input  logic [63:0] i_tot_I,
    input  logic [63:0] i_err_Q,
    input  logic [63:0] i_tot_Q,
    input  logic        i_snap_valid,
    input  logic        i_req_drop,
    input  logic        i_sync_done_I,
    input  logic        i_sync_done_Q,
`ifdef BER_SNAP_TIMESTAMP_EN
    input  logic [31:0] i_tstamp,
`endif
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = ILLEGAL_RDATA;
        o_illegal = 1'b1;
        case (i_addr)
            ADDR_SNAP:     begin o_word = i_snap_count;   o_illegal = 1'b0; end
            ADDR_ERR_I_LO: begin o_word = i_err_I[31:0];  o_illegal = 1'b0; end
            ADDR_ERR_I_HI: begin o_word = i_err_I[63:32]; o_illegal = 1'b0; end
            ADDR_TOT_I_LO: begin o_word = i_tot_I[31:0];  o_illegal = 1'b0; end
            ADDR_TOT_I_HI: begin o_word = i_tot_I[63:32]; o_illegal = 1'b0; end
            ADDR_ERR_Q_LO: begin o_word = i_err_Q[31:0];  o_illegal = 1'b0; end
            ADDR_ERR_Q_HI: begin o_word = i_err_Q[63:32]; o_illegal = 1'b0; end
            ADDR_TOT_Q_LO: begin o_word = i_tot_Q[31:0];  o_illegal = 1'b0; end
            ADDR_TOT_Q_HI: begin o_word = i_tot_Q[63:32]; o_illegal = 1'b0; end
            ADDR_STATUS: begin
                o_word                             = 32'h0;
                o_word[STAT_CNT_MSB:STAT_CNT_LSB]  = i_snap_count[15:0];
                o_word[STAT_REQ_DROP]              = i_req_drop;
                o_word[STAT_SNAP_VALID]            = i_snap_valid;
                o_word[STAT_SYNC_Q]                = i_sync_done_Q;
                o_word[STAT_SYNC_I]                = i_sync_done_I;
                o_illegal                          = 1'b0;
            end
`ifdef BER_SNAP_TIMESTAMP_EN
            ADDR_TSTAMP:   begin o_word = i_tstamp;       o_illegal = 1'b0; end
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ber_snapshot_reg.sv
// ============================================================================
// Module      : ber_snapshot_reg
// Description : Atomic I/Q BER counter snapshot with a 2-cycle request/ack
//               read port. Optional macro BER_SNAP_TIMESTAMP_EN adds a cycle
//               timestamp latched with every snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ber_snapshot_reg
    import ber_snap_pkg::*;
#(
    parameter int CNT_W      = 64,
    parameter int SNAP_CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic [CNT_W-1:0] i_accum_err_I,
    input  logic [CNT_W-1:0] i_accum_tot_I,
    input  logic [CNT_W-1:0] i_accum_err_Q,
    input  logic [CNT_W-1:0] i_accum_tot_Q,
    input  logic             i_sync_done_I,
    input  logic             i_sync_done_Q,
    input  logic             i_req,
    input  logic [3:0]       i_addr,
    output logic             o_ack,
    output logic [31:0]      o_rdata,
    output logic             o_err,
    output logic             o_busy
);

    state_t                state_q,      state_d;
    logic [3:0]            addr_q,       addr_d;
    logic [31:0]           rdata_q,      rdata_d;
    logic                  err_q,        err_d;
    logic [CNT_W-1:0]      snap_err_i_q, snap_err_i_d;
    logic [CNT_W-1:0]      snap_tot_i_q, snap_tot_i_d;
    logic [CNT_W-1:0]      snap_err_q_q, snap_err_q_d;
    logic [CNT_W-1:0]      snap_tot_q_q, snap_tot_q_d;
    logic [SNAP_CNT_W-1:0] snap_count_q, snap_count_d;
    logic                  snap_valid_q, snap_valid_d;
    logic                  req_drop_q,   req_drop_d;

    logic [31:0]           w_word;
    logic                  w_illegal;
    logic                  w_do_snap;

`ifdef BER_SNAP_TIMESTAMP_EN
    logic [31:0]           tstamp_q;
    logic [31:0]           tstamp_snap_q;

    // Latched value equals (clk edges since the reset edge) - 1.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            tstamp_q      <= 32'h0;
            tstamp_snap_q <= 32'h0;
        end else begin
            tstamp_q <= tstamp_q + 32'd1;
            if (w_do_snap) begin
                tstamp_snap_q <= tstamp_q;
            end
        end
    end
`endif

    ber_snap_word_mux u_word_mux (
        .i_addr        (addr_q),
        .i_snap_count  (32'(snap_count_q)),
        .i_err_I       (64'(snap_err_i_q)),
        .i_tot_I       (64'(snap_tot_i_q)),
        .i_err_Q       (64'(snap_err_q_q)),
        .i_tot_Q       (64'(snap_tot_q_q)),
        .i_snap_valid  (snap_valid_q),
        .i_req_drop    (req_drop_q),
        .i_sync_done_I (i_sync_done_I),
        .i_sync_done_Q (i_sync_done_Q),
`ifdef BER_SNAP_TIMESTAMP_EN
        .i_tstamp      (tstamp_snap_q),
`endif
        .o_word        (w_word),
        .o_illegal     (w_illegal)
    );

    assign w_do_snap = (state_q == ST_EXEC) && (addr_q == ADDR_SNAP);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        snap_err_i_d = snap_err_i_q;
        snap_tot_i_d = snap_tot_i_q;
        snap_err_q_d = snap_err_q_q;
        snap_tot_q_d = snap_tot_q_q;
        snap_count_d = snap_count_q;
        snap_valid_d = snap_valid_q;
        req_drop_d   = req_drop_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    state_d = ST_EXEC;
                    addr_d  = i_addr;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                rdata_d = w_word;
                err_d   = w_illegal;
                if (w_do_snap) begin
                    snap_err_i_d = i_accum_err_I;
                    snap_tot_i_d = i_accum_tot_I;
                    snap_err_q_d = i_accum_err_Q;
                    snap_tot_q_d = i_accum_tot_Q;
                    snap_count_d = snap_count_q + SNAP_CNT_W'(1);
                    snap_valid_d = 1'b1;
                end
                if (addr_q == ADDR_STATUS) begin
                    req_drop_d = 1'b0;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A drop in the same cycle as a status-read clear must win.
        if (i_req && (state_q != ST_IDLE)) begin
            req_drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= 4'h0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            snap_err_i_q <= '0;
            snap_tot_i_q <= '0;
            snap_err_q_q <= '0;
            snap_tot_q_q <= '0;
            snap_count_q <= '0;
            snap_valid_q <= 1'b0;
            req_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            snap_err_i_q <= snap_err_i_d;
            snap_tot_i_q <= snap_tot_i_d;
            snap_err_q_q <= snap_err_q_d;
            snap_tot_q_q <= snap_tot_q_d;
            snap_count_q <= snap_count_d;
            snap_valid_q <= snap_valid_d;
            req_drop_q   <= req_drop_d;
        end
    end

    assign o_ack   = (state_q == ST_RESP);
    assign o_err   = o_ack & err_q;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_rdata = rdata_q;

endmodule

`default_nettype wire

// File: doc/ber_snapshot_reg.md
BER_SNAPSHOT_REG -- requirements
Module: ber_snapshot_reg

Interface
REQ-001 SHALL have parameter CNT_W, default 64, width of each BER accumulator input.
REQ-002 SHALL have parameter SNAP_CNT_W, default 16, width of the snapshot counter.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port i_reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have ports i_accum_err_I, i_accum_tot_I, i_accum_err_Q and i_accum_tot_Q, each input, CNT_W wide, carrying the live BER counters.
REQ-006 SHALL have ports i_sync_done_I and i_sync_done_Q, input, 1, the receiver sync flags.
REQ-007 SHALL have port i_req, input, 1, a uBlaze request strobe sampled on clk.
REQ-008 SHALL have port i_addr, input, 4, the request word address.
REQ-009 SHALL have port o_ack, output, 1, a one-cycle response strobe.
REQ-010 SHALL have port o_rdata, output, 32, the response data.
REQ-011 SHALL have port o_err, output, 1, the response error flag, valid only with o_ack.
REQ-012 SHALL have port o_busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC and RESP; the transitions are IDLE->EXEC on i_req, EXEC->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-014 SHALL register i_addr on the IDLE->EXEC transition; i_addr is ignored at all other times.
REQ-015 SHALL, in EXEC with addr 0x0, latch all four counter inputs into snapshot registers in the same clk edge, making the capture atomic and the I/Q values mutually consistent.
REQ-016 SHALL, on a snapshot, set snap_valid and increment snap_count, which wraps from 2^SNAP_CNT_W-1 to 0.
REQ-017 SHALL, in EXEC, load o_rdata per address:
  - 0x0: current snap_count, zero-extended (value before the increment)
  - 0x1/0x2: err_I low/high word
  - 0x3/0x4: tot_I low/high word
  - 0x5/0x6: err_Q low/high word
  - 0x7/0x8: tot_Q low/high word
  - 0x9: status word
REQ-018 SHALL lay out the status word as: [31:16] snap_count, [3] req_drop, [2] snap_valid, [1] i_sync_done_Q, [0] i_sync_done_I, with all other bits 0.
REQ-019 SHALL zero-extend and split counter words when CNT_W is below 64; bits above CNT_W read as 0.
REQ-020 SHALL treat addresses 0xA-0xF as illegal, responding with o_rdata=32'hDEADBEEF and o_err=1; illegal accesses SHALL NOT change any state.
REQ-021 SHALL drive o_ack=1 for exactly one cycle in RESP, giving a fixed latency of 2 clk from the accepted i_req to o_ack.
REQ-022 SHALL hold o_rdata stable from RESP until the next EXEC.
REQ-023 SHALL ignore i_req asserted while o_busy=1 and set the sticky flag req_drop.
REQ-024 SHALL clear req_drop in the EXEC of a status read (0x9); the read returns the pre-clear value.
REQ-025 SHALL give a drop occurring in that same EXEC cycle priority over the clear.
REQ-026 SHALL return the reset value 0 for data-word reads made before any snapshot (snap_valid=0).
REQ-027 SHALL NOT let live counter changes alter the snapshot registers between snapshots.

Reset
REQ-028 SHALL, while i_reset=1 at a clk edge, set the FSM to IDLE and clear o_ack, o_err, o_busy, o_rdata, all snapshot registers, snap_count, snap_valid and req_drop to 0.
REQ-029 SHALL, on reset mid-transaction (EXEC or RESP), abort the transaction with no o_ack and no snapshot side effects.

Configuration
REQ-030 SHALL, with macro BER_SNAP_TIMESTAMP_EN defined, include a 32-bit free-running cycle counter that is cleared by reset and wraps.
REQ-031 SHALL, with BER_SNAP_TIMESTAMP_EN defined, latch that counter with each snapshot, readable at 0xA; only 0xB-0xF are then illegal.
REQ-032 SHALL, without BER_SNAP_TIMESTAMP_EN, contain no timestamp logic and treat 0xA as illegal.

Structure
REQ-033 SHALL define the following in a shared package ber_snap_pkg:
  - address constants ADDR_SNAP through ADDR_STATUS and ADDR_TSTAMP
  - the FSM state encoding
  - ILLEGAL_RDATA = 32'hDEADBEEF
  - status-word bit positions
REQ-034 SHALL place the address-to-word selection in one sub-module, ber_snap_word_mux, which is purely combinational; the FSM, snapshot registers and flags stay in ber_snapshot_reg.

Verification
REQ-035 SHALL check: counters err_I=64'h0000_0001_0000_0005 and tot_I=64'h0000_0002_0000_0000; req 0x0, then read 0x1 and 0x2 -> 0x00000005 and 0x00000001, each o_ack exactly 2 cycles after req.
REQ-036 SHALL check: snapshot taken, live counters then change, read 0x3 -> the pre-change value; read 0x9 -> snap_valid=1, snap_count=1.
REQ-037 SHALL check: i_req held 3 consecutive cycles -> exactly one o_ack; status read -> req_drop=1; second status read -> req_drop=0.
REQ-038 SHALL check: req addr 0xC -> o_ack with o_rdata=32'hDEADBEEF and o_err=1; snap_count unchanged.
REQ-039 SHALL check: SNAP_CNT_W=2 with 4 snapshots -> snap_count=0; i_reset asserted in EXEC of a snapshot -> no o_ack, snap_valid=0.
REQ-040 SHALL check: with BER_SNAP_TIMESTAMP_EN, snapshot at cycle 100 after reset -> read 0xA returns a value of about 100, matching the documented offset.
